// File: rtl/summation_unit.sv
`default_nettype none
// ============================================================================
//  Module      : summation_unit
//  Description : Sequential summation engine. On start it computes
//                value + (value-1) + ... + 1 (modulo 2^WIDTH) using a Moore
//                control FSM that drives a down-counter / accumulator datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module summation_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active-low
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] total,
    output logic             ready,
    output logic             overflow,
    output logic             mZero
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_DEC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Control strobes from the FSM to the datapath
    logic w_set;
    logic w_rac;
    logic w_cac;
    logic w_dec;
    logic w_ready;

    // Datapath registers
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_ac;
    logic             r_ovf;

    // Extended sum exposes the carry out of the accumulator addition
    logic [WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_ac} + {1'b0, r_m};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and Moore strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_set       = 1'b0;
        w_rac       = 1'b0;
        w_cac       = 1'b0;
        w_dec       = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_INIT;
            end
            S_INIT: begin
                w_set       = 1'b1;
                w_rac       = 1'b1;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_state_nxt = mZero ? S_DONE : S_ADD;
            end
            S_ADD: begin
                w_cac       = 1'b1;
                w_state_nxt = S_DEC;
            end
            S_DEC: begin
                w_dec       = 1'b1;
                w_state_nxt = S_CHECK;
            end
            S_DONE: begin
                w_ready = 1'b1;
                // Stay here while start is held so a level request runs once
                if (!start) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Down-counter M: loaded from value on set, decremented on dec
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m <= '0;
        end else if (w_set) begin
            r_m <= value;
        end else if (w_dec) begin
            r_m <= r_m - 1'b1;
        end
    end

    // Accumulator AC: cleared on rac, accumulates M on cac
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ac <= '0;
        end else if (w_rac) begin
            r_ac <= '0;
        end else if (w_cac) begin
            r_ac <= w_sum[WIDTH-1:0];
        end
    end

    // Sticky overflow: cleared at the start of a run, set on any carry out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_rac) begin
            r_ovf <= 1'b0;
        end else if (w_cac && w_sum[WIDTH]) begin
            r_ovf <= 1'b1;
        end
    end

    assign mZero    = (r_m == '0);
    assign total    = r_ac;
    assign overflow = r_ovf;
    assign ready    = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_summation_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_summation_unit
//  Description : Directed self-checking bench for summation_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_summation_unit;

    localparam int WIDTH = 8;
    localparam int C_MAX_CYCLES = 200;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] total;
    logic             ready;
    logic             overflow;
    logic             mZero;

    int n_vec;
    int n_err;

    summation_unit #(.WIDTH(WIDTH)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .total    (total),
        .ready    (ready),
        .overflow (overflow),
        .mZero    (mZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the vector and reports a miscompare
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Launch a run at the next edge k, count edges until ready, return latency
    task automatic launch(input logic [WIDTH-1:0] n, input bit drop_start, output int lat);
        @(negedge clk);
        value = n;
        start = 1'b1;
        @(posedge clk);          // edge k
        #1;
        if (drop_start) start = 1'b0;
        lat = 0;
        for (int i = 0; i < C_MAX_CYCLES; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (ready) break;
        end
        if (!ready) lat = -1;
    endtask

    // Full run with start pulsed: check latency, result, and ready falling
    task automatic run(input string tag, input logic [WIDTH-1:0] n,
                       input int exp_lat, input logic [WIDTH-1:0] exp_tot, input logic exp_ovf);
        int lat;
        launch(n, 1'b1, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_total"}, total, exp_tot);
        chk({tag, "_ovf"}, overflow, exp_ovf);
        chk({tag, "_mzero"}, mZero, 1'b1);
        @(posedge clk);
        #1;
        chk({tag, "_ready_fall"}, ready, 1'b0);
        chk({tag, "_total_hold"}, total, exp_tot);
    endtask

    initial begin
        int lat;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b0;
        value = '0;

        // Reset state
        #12;
        chk("rst_total", total, 0);
        chk("rst_ready", ready, 0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_mzero", mZero, 1);
        @(negedge clk);
        rst = 1'b1;

        // Basic runs
        run("n1",  8'd1,  5,  8'd1,  1'b0);
        run("n10", 8'd10, 32, 8'h37, 1'b0);
        run("n0",  8'd0,  2,  8'd0,  1'b0);

        // Overflow boundary and clearing on the next run
        run("n22", 8'd22, 68, 8'd253, 1'b0);
        run("n23", 8'd23, 71, 8'd20,  1'b1);
        run("n3",  8'd3,  11, 8'd6,   1'b0);

        // Asynchronous reset in the middle of an N=10 run
        @(negedge clk);
        value = 8'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("mid_total_nonzero", (total != 0), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_total", total, 0);
        chk("arst_ready", ready, 0);
        chk("arst_ovf",   overflow, 0);
        chk("arst_mzero", mZero, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_ready", ready, 0);
        chk("post_rst_idle_total", total, 0);
        // IDLE is confirmed by the standard latency of a fresh run
        run("post_rst_n0", 8'd0, 2, 8'd0, 1'b0);

        // Disturbances while busy on a value=5 run; start held into DONE
        @(negedge clk);
        value = 8'd5;
        start = 1'b1;
        @(posedge clk);          // edge k
        #1;
        start = 1'b0;
        lat = 0;
        for (int i = 0; i < C_MAX_CYCLES; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (ready) break;
            value = 8'hFF;
            start = ~start;
            if (lat >= 12) start = 1'b1;
        end
        if (!ready) lat = -1;
        chk("busy_lat",   lat, 17);
        chk("busy_total", total, 15);
        chk("busy_ovf",   overflow, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_ready", ready, 1);
        chk("hold_total", total, 15);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_release_ready", ready, 0);
        chk("hold_release_total", total, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
